// File: rtl/vend_pkg.sv
// Shared types and helpers for the vend dispense sequencer: state encoding,
// product select constants and the one-hot legality check.
package vend_pkg;

    typedef enum logic [2:0] {
        IDLE,
        MOTOR,
        GAP,
        COIN,
        DONE
    } state_t;

    localparam logic [3:0] PROD_A    = 4'b0001;
    localparam logic [3:0] PROD_B    = 4'b0010;
    localparam logic [3:0] PROD_C    = 4'b0100;
    localparam logic [3:0] PROD_D    = 4'b1000;
    localparam logic [3:0] PROD_NONE = 4'b0000;

    // Exactly one bit set: non-zero and clearing the lowest set bit leaves zero.
    function automatic logic is_onehot(input logic [3:0] sel);
        return (sel != 4'd0) && ((sel & (sel - 4'd1)) == 4'd0);
    endfunction

endpackage

// File: rtl/vend_timer.sv
// 8-bit loadable down-counter that parks at zero; expired flags the zero value
// so the sequencer can leave a state on the cycle the count reads 0.
module vend_timer (
    input  logic       clk,
    input  logic       clr,
    input  logic       load,
    input  logic [7:0] load_value,
    output logic [7:0] value,
    output logic       expired
);

    always_ff @(posedge clk) begin
        if (clr) begin
            value <= 8'd0;
        end else if (load) begin
            value <= load_value;
        end else if (value != 8'd0) begin
            value <= value - 8'd1;
        end
    end

    assign expired = (value == 8'd0);

endmodule

// File: rtl/vend_dispense_sequencer.sv
// Runs one vend job: pulses the selected product motor, then ejects the change
// one nickel at a time with fixed pulse/gap timing, and reports done.
module vend_dispense_sequencer
    import vend_pkg::*;
#(
    parameter int unsigned MOTOR_CYCLES = 8,
    parameter int unsigned PULSE_CYCLES = 4,
    parameter int unsigned GAP_CYCLES   = 4,
    parameter int unsigned CHG_W        = 3
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             vend_req,
    input  logic [3:0]       vend_prod,
    input  logic [CHG_W-1:0] vend_change,
    output logic             vend_ack,
    output logic             vend_err,
    output logic             busy,
    output logic [3:0]       motor,
    output logic             coin_out,
    output logic [CHG_W-1:0] coins_left,
    output logic             done
);

    localparam logic [7:0] MOTOR_LOAD = 8'(MOTOR_CYCLES - 1);
    localparam logic [7:0] PULSE_LOAD = 8'(PULSE_CYCLES - 1);
    localparam logic [7:0] GAP_LOAD   = 8'(GAP_CYCLES - 1);

    state_t           state;
    state_t           state_next;
    logic [3:0]       prod_q;
    logic [3:0]       prod_next;
    logic [CHG_W-1:0] coins_next;
    logic             ack_next;
    logic             err_next;
    logic             tmr_load;
    logic [7:0]       tmr_load_value;
    logic [7:0]       tmr_count;
    logic             tmr_expired;

    vend_timer u_timer (
        .clk        (clk),
        .clr        (clr),
        .load       (tmr_load),
        .load_value (tmr_load_value),
        .value      (tmr_count),
        .expired    (tmr_expired)
    );

    // Outputs are registered from the next state so they line up with the state they describe.
    always_ff @(posedge clk) begin
        if (clr) begin
            state      <= IDLE;
            prod_q     <= 4'd0;
            coins_left <= '0;
            vend_ack   <= 1'b0;
            vend_err   <= 1'b0;
            busy       <= 1'b0;
            motor      <= 4'd0;
            coin_out   <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= state_next;
            prod_q     <= prod_next;
            coins_left <= coins_next;
            vend_ack   <= ack_next;
            vend_err   <= err_next;
            busy       <= (state_next != IDLE);
            motor      <= (state_next == MOTOR) ? prod_next : 4'd0;
            coin_out   <= (state_next == COIN);
            done       <= (state_next == DONE);
        end
    end

    always_comb begin
        state_next     = state;
        prod_next      = prod_q;
        coins_next     = coins_left;
        ack_next       = 1'b0;
        err_next       = 1'b0;
        tmr_load       = 1'b0;
        tmr_load_value = 8'd0;
        case (state)
            IDLE: begin
                if (vend_req) begin
                    if (is_onehot(vend_prod)) begin
                        state_next     = MOTOR;
                        prod_next      = vend_prod;
                        coins_next     = vend_change;
                        ack_next       = 1'b1;
                        tmr_load       = 1'b1;
                        tmr_load_value = MOTOR_LOAD;
                    end else begin
                        err_next = 1'b1;
                    end
                end
            end
            MOTOR: begin
                if (tmr_expired) begin
                    state_next     = GAP;
                    tmr_load       = 1'b1;
                    tmr_load_value = GAP_LOAD;
                end
            end
            GAP: begin
                if (tmr_expired) begin
                    tmr_load = 1'b1;
                    if (coins_left != '0) begin
                        state_next     = COIN;
                        tmr_load_value = PULSE_LOAD;
                    end else begin
                        state_next = DONE;
                    end
                end
            end
            COIN: begin
                // The nickel is counted as ejected when its pulse ends.
                if (tmr_expired) begin
                    state_next     = GAP;
                    coins_next     = coins_left - CHG_W'(1);
                    tmr_load       = 1'b1;
                    tmr_load_value = GAP_LOAD;
                end
            end
            DONE: begin
                state_next = IDLE;
                tmr_load   = 1'b1;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    coin_pulse_bounded: assert property (@(posedge clk) disable iff (clr)
        (state == COIN) |-> (tmr_count <= PULSE_LOAD));

endmodule

// File: tb/tb_vend_dispense_sequencer.sv
// Self-checking bench: cycle-by-cycle reference model, table of request vectors,
// hand-written multi-cycle sequences and a randomized soak.
module tb_vend_dispense_sequencer;
    import vend_pkg::*;

    localparam int M = 8;
    localparam int P = 4;
    localparam int G = 4;

    logic       clk = 1'b0;
    logic       clr = 1'b1;
    logic       vend_req = 1'b0;
    logic [3:0] vend_prod = 4'd0;
    logic [2:0] vend_change = 3'd0;
    logic       vend_ack, vend_err, busy, coin_out, done;
    logic [3:0] motor;
    logic [2:0] coins_left;

    logic       req2 = 1'b0;
    logic [3:0] prod2 = 4'd0;
    logic [2:0] change2 = 3'd0;
    logic       ack2, err2, busy2, coin2, done2;
    logic [3:0] motor2;
    logic [2:0] coins2;

    int checks = 0;
    int errors = 0;
    bit check_en = 1'b0;

    typedef struct packed {
        logic       ack;
        logic       err;
        logic       busy;
        logic [3:0] motor;
        logic       coin;
        logic [2:0] coins;
        logic       done;
    } obs_t;

    typedef struct {
        logic [3:0] prod;
        logic [2:0] change;
        logic       exp_ack;
        logic       exp_err;
        logic [3:0] exp_motor;
        logic [2:0] exp_coins;
    } vec_t;

    obs_t dut_obs;
    assign dut_obs = {vend_ack, vend_err, busy, motor, coin_out, coins_left, done};

    vend_dispense_sequencer dut (
        .clk(clk), .clr(clr), .vend_req(vend_req), .vend_prod(vend_prod),
        .vend_change(vend_change), .vend_ack(vend_ack), .vend_err(vend_err),
        .busy(busy), .motor(motor), .coin_out(coin_out), .coins_left(coins_left),
        .done(done)
    );

    vend_dispense_sequencer #(.MOTOR_CYCLES(1), .PULSE_CYCLES(1), .GAP_CYCLES(1), .CHG_W(3)) dut_fast (
        .clk(clk), .clr(clr), .vend_req(req2), .vend_prod(prod2),
        .vend_change(change2), .vend_ack(ack2), .vend_err(err2),
        .busy(busy2), .motor(motor2), .coin_out(coin2), .coins_left(coins2),
        .done(done2)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic req, input logic [3:0] prod, input logic [2:0] change);
        vend_req    = req;
        vend_prod   = prod;
        vend_change = change;
    endtask

    task automatic waitCycle();
        @(negedge clk);
    endtask

    // Reference model: a job is a timeline indexed by cycles since acceptance.
    function automatic int jobLen(input int n);
        return M + G + n * (P + G) + 1;
    endfunction

    function automatic obs_t modelOut(input bit act, input int k, input logic [3:0] p, input int n, input bit err);
        obs_t r;
        int t;
        int per;
        r = '0;
        r.err = err;
        per = P + G;
        if (act) begin
            r.busy  = 1'b1;
            r.ack   = (k == 1);
            r.coins = 3'(n);
            if (k <= M) begin
                r.motor = p;
            end else if (k == jobLen(n)) begin
                r.done  = 1'b1;
                r.coins = 3'd0;
            end else if (k > M + G) begin
                t = k - M - G - 1;
                r.coin  = ((t % per) < P);
                r.coins = 3'(n - t / per - (((t % per) < P) ? 0 : 1));
            end
        end
        return r;
    endfunction

    bit         m_active = 1'b0;
    int         m_k = 0;
    logic [3:0] m_prod = 4'd0;
    int         m_n = 0;
    bit         m_err = 1'b0;

    always @(posedge clk) begin
        if (clr) begin
            m_active <= 1'b0;
            m_err    <= 1'b0;
        end else if (m_active) begin
            m_err <= 1'b0;
            if (m_k == jobLen(m_n)) m_active <= 1'b0;
            else m_k <= m_k + 1;
        end else if (vend_req && $countones(vend_prod) == 1) begin
            m_active <= 1'b1;
            m_k      <= 1;
            m_prod   <= vend_prod;
            m_n      <= int'(vend_change);
            m_err    <= 1'b0;
        end else begin
            m_err <= vend_req;
        end
    end

    always @(negedge clk) begin
        if (check_en)
            checkOutput("model", 32'(dut_obs), 32'(modelOut(m_active, m_k, m_prod, m_n, m_err)));
    end

    initial begin
        vec_t vecs[6];
        int acks;
        int dones;
        int coin_cycles;
        logic exp_coin;

        vecs[0] = '{PROD_A, 3'd5, 1'b1, 1'b0, PROD_A, 3'd5};
        vecs[1] = '{PROD_D, 3'd7, 1'b1, 1'b0, PROD_D, 3'd7};
        vecs[2] = '{4'b0011, 3'd2, 1'b0, 1'b1, 4'd0, 3'd0};
        vecs[3] = '{4'b1111, 3'd0, 1'b0, 1'b1, 4'd0, 3'd0};
        vecs[4] = '{PROD_NONE, 3'd4, 1'b0, 1'b1, 4'd0, 3'd0};
        vecs[5] = '{PROD_C, 3'd0, 1'b1, 1'b0, PROD_C, 3'd0};

        clr = 1'b1;
        applyStimulus(1'b0, 4'd0, 3'd0);
        repeat (2) waitCycle();
        checkOutput("reset_state", 32'(dut_obs), 32'd0);
        checkOutput("reset_state_fast", 32'({ack2, err2, busy2, motor2, coin2, coins2, done2}), 32'd0);
        check_en = 1'b1;
        clr = 1'b0;
        waitCycle();

        // Plan 1: product B, no change.
        applyStimulus(1'b1, PROD_B, 3'd0);
        waitCycle();
        checkOutput("t1_ack_c1", 32'(vend_ack), 32'd1);
        checkOutput("t1_motor_c1", 32'(motor), 32'(PROD_B));
        applyStimulus(1'b0, 4'd0, 3'd0);
        repeat (7) waitCycle();
        checkOutput("t1_motor_c8", 32'(motor), 32'(PROD_B));
        checkOutput("t1_ack_c8", 32'(vend_ack), 32'd0);
        waitCycle();
        checkOutput("t1_motor_c9", 32'(motor), 32'd0);
        repeat (3) waitCycle();
        checkOutput("t1_done_c12", 32'(done), 32'd0);
        waitCycle();
        checkOutput("t1_done_c13", 32'(done), 32'd1);
        checkOutput("t1_busy_c13", 32'(busy), 32'd1);
        waitCycle();
        checkOutput("t1_busy_c14", 32'(busy), 32'd0);

        // Plan 2: product C, three nickels.
        applyStimulus(1'b1, PROD_C, 3'd3);
        coin_cycles = 0;
        dones = 0;
        for (int c = 1; c <= 38; c++) begin
            waitCycle();
            if (c == 1) applyStimulus(1'b0, 4'd0, 3'd0);
            coin_cycles += int'(coin_out);
            dones += int'(done);
            case (c)
                1:            checkOutput("t2_coins_c1", 32'(coins_left), 32'd3);
                12:           checkOutput("t2_coin_c12", 32'(coin_out), 32'd0);
                13, 21, 29:   checkOutput("t2_coin_start", 32'(coin_out), 32'd1);
                16, 24, 32:   checkOutput("t2_coin_end", 32'(coin_out), 32'd1);
                17:           checkOutput("t2_coins_c17", 32'(coins_left), 32'd2);
                25:           checkOutput("t2_coins_c25", 32'(coins_left), 32'd1);
                33:           checkOutput("t2_coins_c33", 32'(coins_left), 32'd0);
                36:           checkOutput("t2_done_c36", 32'(done), 32'd0);
                37:           checkOutput("t2_done_c37", 32'(done), 32'd1);
                38:           checkOutput("t2_busy_c38", 32'(busy), 32'd0);
                default: ;
            endcase
        end
        checkOutput("t2_coin_cycles", 32'(coin_cycles), 32'd12);
        checkOutput("t2_done_count", 32'(dones), 32'd1);

        // Plan 3: illegal product selects.
        applyStimulus(1'b1, PROD_NONE, 3'd0);
        waitCycle();
        checkOutput("t3_err_zero", 32'({vend_err, vend_ack, busy, motor}), 32'({1'b1, 1'b0, 1'b0, 4'd0}));
        applyStimulus(1'b1, 4'b0101, 3'd2);
        waitCycle();
        checkOutput("t3_err_two", 32'({vend_err, vend_ack, busy, motor}), 32'({1'b1, 1'b0, 1'b0, 4'd0}));
        applyStimulus(1'b0, 4'd0, 3'd0);
        waitCycle();
        checkOutput("t3_err_clear", 32'(vend_err), 32'd0);

        // Plan 4: request held through a whole job.
        applyStimulus(1'b1, PROD_A, 3'd1);
        acks = 0;
        for (int c = 1; c <= 22; c++) begin
            waitCycle();
            acks += int'(vend_ack);
            if (c == 21) checkOutput("t4_done_c21", 32'(done), 32'd1);
            if (c == 22) checkOutput("t4_idle_c22", 32'(busy), 32'd0);
        end
        checkOutput("t4_single_ack", 32'(acks), 32'd1);
        waitCycle();
        checkOutput("t4_second_ack", 32'(vend_ack), 32'd1);
        applyStimulus(1'b0, 4'd0, 3'd0);
        repeat (21) waitCycle();
        checkOutput("t4_second_idle", 32'(busy), 32'd0);

        // Plan 5: clear during the second coin pulse.
        applyStimulus(1'b1, PROD_D, 3'd3);
        waitCycle();
        applyStimulus(1'b0, 4'd0, 3'd0);
        repeat (20) waitCycle();
        checkOutput("t5_coin_c21", 32'(coin_out), 32'd1);
        waitCycle();
        clr = 1'b1;
        waitCycle();
        clr = 1'b0;
        checkOutput("t5_after_clr", 32'(dut_obs), 32'd0);
        dones = 0;
        for (int c = 0; c < 30; c++) begin
            waitCycle();
            dones += int'(done);
        end
        checkOutput("t5_no_done", 32'(dones), 32'd0);
        applyStimulus(1'b1, PROD_A, 3'd0);
        waitCycle();
        checkOutput("t5_fresh_ack", 32'({vend_ack, motor}), 32'({1'b1, PROD_A}));
        applyStimulus(1'b0, 4'd0, 3'd0);
        repeat (13) waitCycle();
        checkOutput("t5_fresh_idle", 32'(busy), 32'd0);

        // Table of single requests from IDLE, each followed by a clear.
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b1, vecs[i].prod, vecs[i].change);
            waitCycle();
            checkOutput($sformatf("vec%0d", i),
                32'({vend_ack, vend_err, busy, motor, coins_left}),
                32'({vecs[i].exp_ack, vecs[i].exp_err, vecs[i].exp_ack, vecs[i].exp_motor, vecs[i].exp_coins}));
            applyStimulus(1'b0, 4'd0, 3'd0);
            clr = 1'b1;
            waitCycle();
            clr = 1'b0;
        end

        // Plan 6: minimum timing, seven nickels, on the fast instance.
        req2 = 1'b1;
        prod2 = PROD_C;
        change2 = 3'd7;
        for (int c = 1; c <= 18; c++) begin
            waitCycle();
            if (c == 1) req2 = 1'b0;
            exp_coin = (c >= 3) && (c <= 15) && (c % 2 == 1);
            checkOutput($sformatf("t6_c%0d", c),
                32'({motor2, coin2, done2, busy2}),
                32'({(c == 1) ? PROD_C : 4'd0, exp_coin, (c == 17), (c <= 17)}));
            if (c == 3)  checkOutput("t6_coins_c3", 32'(coins2), 32'd7);
            if (c == 4)  checkOutput("t6_coins_c4", 32'(coins2), 32'd6);
            if (c == 16) checkOutput("t6_coins_c16", 32'(coins2), 32'd0);
        end

        // Randomized soak against the model.
        for (int i = 0; i < 1500; i++) begin
            clr = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 3) == 0)
                applyStimulus($urandom_range(0, 3) != 0, 4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)));
            else
                applyStimulus($urandom_range(0, 3) != 0, 4'(1 << $urandom_range(0, 3)), 3'($urandom_range(0, 7)));
            waitCycle();
        end
        clr = 1'b0;
        applyStimulus(1'b0, 4'd0, 3'd0);
        waitCycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/vend_dispense_sequencer.md
Name: vend_dispense_sequencer

Overview:
Back-end sequencer that runs after the vending controller reaches a change state. It accepts one vend job: a one-hot product select and a change count in nickels. It pulses the selected product motor, then ejects the change one nickel at a time with fixed pulse/gap timing, and reports done. It sits between the vending controller (requester) and the motor/coin-hopper drivers.

Parameters:
MOTOR_CYCLES, 8, motor-on duration in clk cycles (legal 1..255)
PULSE_CYCLES, 4, coin_out high duration per nickel (legal 1..255)
GAP_CYCLES, 4, idle gap after motor and after every coin pulse (legal 1..255)
CHG_W, 3, width of change count in nickels (max 7 nickels = 35 cents)

Ports:
clk  input  1  system clock
clr  input  1  reset; synchronous, active-high
vend_req  input  1  job request; level, sampled only in IDLE
vend_prod  input  4  product select; must be one-hot
vend_change  input  CHG_W  nickels to return
vend_ack  output  1  one-cycle pulse: job accepted
vend_err  output  1  one-cycle pulse: request rejected (vend_prod not one-hot)
busy  output  1  high in every state except IDLE
motor  output  4  product motor drive (latched vend_prod during MOTOR, else 0)
coin_out  output  1  nickel eject drive
coins_left  output  CHG_W  nickels still to eject
done  output  1  one-cycle pulse: job finished

Behaviour:
- All outputs are registered. On clr (sampled at posedge clk), state = IDLE and every output = 0, including coins_left, plus the internal timer. This holds even mid-job; the job is abandoned with no done pulse.
- States: IDLE, MOTOR, GAP, COIN, DONE. A single 8-bit down-counter timer is loaded on every state entry with (duration-1). The state exits on the cycle the timer reads 0.
- IDLE: busy=0.
  - vend_req=1 and vend_prod one-hot: latch prod and change, go to MOTOR. vend_ack=1 during the first MOTOR cycle.
  - vend_req=1 and vend_prod not one-hot (0 or ≥2 bits): vend_err=1 for the next cycle, stay IDLE, latch nothing.
- MOTOR: motor=latched prod for exactly MOTOR_CYCLES cycles, then go to GAP.
- GAP: all drives 0 for GAP_CYCLES cycles. At expiry: coins_left>0 → COIN; coins_left=0 → DONE.
- COIN: coin_out=1 for exactly PULSE_CYCLES cycles. coins_left decrements by 1 on the exit edge, which is visible in the first following GAP cycle. Then go to GAP.
- DONE: done=1 and busy=1 for one cycle, then go to IDLE. A new request can be sampled in the first IDLE cycle.
- vend_req while busy: ignored, no ack and no err. The requester must hold or re-issue it.
- Latency from the accepting edge to the done cycle: MOTOR_CYCLES + GAP_CYCLES + n×(PULSE_CYCLES + GAP_CYCLES) + 1, where n = vend_change.
- motor and coin_out are never high in the same cycle. coin_out is never high for more than PULSE_CYCLES consecutive cycles.
- vend_change=0: no COIN state is visited.

Decomposition:
- Shared package vend_pkg: state enum (IDLE, MOTOR, GAP, COIN, DONE), product one-hot constants, and a one-hot check function.
- Sub-module vend_timer: 8-bit loadable down-counter with load, value, and expired outputs, instantiated once.

Test Plan:
1. Defaults; clr, then vend_req with vend_prod=4'b0010, vend_change=0 → ack on cycle 1; motor=4'b0010 on cycles 1–8; drives 0 on cycles 9–12; done on cycle 13; busy=0 from cycle 14.
2. vend_prod=4'b0100, vend_change=3 → three coin_out pulses of 4 cycles each, starting cycles 13, 21, 29; coins_left steps 3→2→1→0 at cycles 17, 25, 33; done on cycle 37.
3. vend_req with vend_prod=4'b0000, then with 4'b0101 → vend_err pulse each time, busy stays 0, motor stays 0, no ack.
4. Second vend_req asserted throughout job 1 (change=1) → exactly one ack for job 1; job 2 acked on the cycle after the first IDLE cycle following done.
5. clr asserted during the second COIN pulse of a change=3 job → next cycle: coin_out=0, coins_left=0, busy=0, no done pulse; a fresh request is then accepted normally.
6. vend_change=7 with MOTOR/PULSE/GAP = 1/1/1 → seven 1-cycle coin pulses separated by 1-cycle gaps; done on cycle 1+1+7×2+1=17.
